// File: rtl/key_event_if.sv
// Keyboard key-state bundle in, conditioned command pulses out.
interface key_event_if;
  logic [511:0] key_down;
  logic         key_valid;
  logic         key_U;
  logic         key_D;
  logic         key_L;
  logic         key_R;
  logic         key_C;
  logic         any_key_held;

  modport master (
    output key_down, key_valid,
    input  key_U, key_D, key_L, key_R,
    input  key_C, any_key_held
  );

  modport slave (
    input  key_down, key_valid,
    output key_U, key_D, key_L, key_R,
    output key_C, any_key_held
  );
endinterface

// File: rtl/key_event_gen.sv
// Turns PS/2 held-key state into one-cycle command pulses,
// with auto-repeat on the most recently pressed direction key.
module key_event_gen #(
  parameter logic [8:0] CODE_UP      = 9'h01D,
  parameter logic [8:0] CODE_LT      = 9'h01C,
  parameter logic [8:0] CODE_DW      = 9'h01B,
  parameter logic [8:0] CODE_RT      = 9'h023,
  parameter logic [8:0] CODE_EN      = 9'h05A,
  parameter int         REPEAT_DELAY = 50_000_000,
  parameter int         REPEAT_RATE  = 10_000_000,
  parameter int         CNT_W        = 27
) (
  input logic        clk,
  input logic        rst,
  key_event_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DLY_LAST  =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST =
    CNT_W'(REPEAT_RATE - 1);

  // held/rise bit order: {EN, RT, LT, DW, UP}
  logic [4:0]       held;
  logic [4:0]       nxt_held;
  logic [4:0]       rise;
  logic [4:0]       pulse;
  logic [3:0]       dir_rise;
  logic [3:0]       pick;
  logic [3:0]       active;
  logic [3:0]       nxt_active;
  logic [3:0]       rep_vec;
  logic [1:0]       state;
  logic [1:0]       nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             tick;
  logic             drop;
  logic             any_q;
  logic             unused_key_down;

  assign unused_key_down = ^bus.key_down;

  assign nxt_held = bus.key_valid ?
    {bus.key_down[CODE_EN], bus.key_down[CODE_RT],
     bus.key_down[CODE_LT], bus.key_down[CODE_DW],
     bus.key_down[CODE_UP]} : held;

  assign rise     = nxt_held & ~held;
  assign dir_rise = rise[3:0];
  // lowest set bit gives U>D>L>R priority
  assign pick     = dir_rise & (~dir_rise + 4'd1);
  assign drop     = |(active & ~nxt_held[3:0]);

  assign tick =
    (state == DELAY  && cnt == DLY_LAST) ||
    (state == REPEAT && cnt == RATE_LAST);

  always_comb begin
    nxt_state  = state;
    nxt_active = active;
    nxt_cnt    = cnt;
    rep_vec    = '0;
    if (|dir_rise) begin
      nxt_state  = DELAY;
      nxt_active = pick;
      nxt_cnt    = '0;
    end else if (state != IDLE) begin
      if (drop) begin
        nxt_state  = IDLE;
        nxt_active = '0;
        nxt_cnt    = '0;
      end else if (tick) begin
        nxt_state = REPEAT;
        nxt_cnt   = '0;
        // an ENTER pulse swallows the repeat but keeps cadence
        if (!rise[4]) rep_vec = active;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held   <= '0;
      pulse  <= '0;
      any_q  <= 1'b0;
      state  <= IDLE;
      active <= '0;
      cnt    <= '0;
    end else begin
      held   <= nxt_held;
      pulse  <= {rise[4], dir_rise | rep_vec};
      any_q  <= |nxt_held;
      state  <= nxt_state;
      active <= nxt_active;
      cnt    <= nxt_cnt;
    end
  end

  assign bus.key_U        = pulse[0];
  assign bus.key_D        = pulse[1];
  assign bus.key_L        = pulse[2];
  assign bus.key_R        = pulse[3];
  assign bus.key_C        = pulse[4];
  assign bus.any_key_held = any_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed and random stimulus for key_event_gen against a
// deadline-based reference model of the key/repeat rules.
module tb_key_event_gen;

  localparam int D = 8;
  localparam int R = 4;

  localparam logic [8:0] C_UP = 9'h01D;
  localparam logic [8:0] C_LT = 9'h01C;
  localparam logic [8:0] C_DW = 9'h01B;
  localparam logic [8:0] C_RT = 9'h023;
  localparam logic [8:0] C_EN = 9'h05A;

  // key set encoding: bit0 W, bit1 S, bit2 A, bit3 D, bit4 ENTER
  localparam bit [4:0] K_W  = 5'b00001;
  localparam bit [4:0] K_S  = 5'b00010;
  localparam bit [4:0] K_A  = 5'b00100;
  localparam bit [4:0] K_D  = 5'b01000;
  localparam bit [4:0] K_EN = 5'b10000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  key_event_if bus();

  key_event_gen #(
    .REPEAT_DELAY(D),
    .REPEAT_RATE (R),
    .CNT_W       (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int       n_cmp = 0;
  int       n_err = 0;
  longint   cyc   = 0;
  bit [4:0] m_held;
  int       m_active;
  longint   m_due;

  task automatic check(input string tag,
                       input logic [5:0] obs,
                       input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the next cycle, compare.
  task automatic step(input string tag, input bit r,
                      input bit v, input bit [4:0] k);
    bit [4:0]    nh;
    bit [4:0]    rs;
    bit [4:0]    out;
    logic [5:0]  exp;
    logic [5:0]  obs;
    logic [511:0] kd;
    kd = {16{$urandom()}};
    kd[C_UP] = k[0];
    kd[C_DW] = k[1];
    kd[C_LT] = k[2];
    kd[C_RT] = k[3];
    kd[C_EN] = k[4];
    rst           = r;
    bus.key_valid = v;
    bus.key_down  = kd;
    if (r) begin
      m_held   = '0;
      m_active = -1;
      exp      = '0;
    end else begin
      nh  = v ? k : m_held;
      rs  = nh & ~m_held;
      out = rs;
      if (rs[3:0] != 0) begin
        for (int i = 3; i >= 0; i--)
          if (rs[i]) m_active = i;
        m_due = cyc + 1 + D;
      end else if (m_active >= 0 && !nh[m_active]) begin
        m_active = -1;
      end else if (m_active >= 0 && cyc + 1 == m_due) begin
        if (!rs[4]) out[m_active] = 1'b1;
        m_due = m_due + R;
      end
      m_held = nh;
      exp = {out[4], out[3], out[2], out[1], out[0], |nh};
    end
    @(posedge clk);
    #1;
    cyc++;
    obs = {bus.key_C, bus.key_R, bus.key_L, bus.key_D,
           bus.key_U, bus.any_key_held};
    check(tag, obs, exp);
  endtask

  task automatic idle(input string tag, input int n,
                      input bit [4:0] k);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, k);
  endtask

  bit [4:0] cur;

  initial begin
    m_held   = '0;
    m_active = -1;
    m_due    = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_down  = '0;

    step("reset", 1'b1, 1'b0, '0);
    step("reset", 1'b1, 1'b0, '0);
    idle("idle", 7, '0);

    // W press, hold into repeat, release mid-repeat
    step("w_press", 1'b0, 1'b1, K_W);
    idle("w_hold", 13, K_W);
    step("w_rel", 1'b0, 1'b1, '0);
    idle("w_idle", 10, '0);

    // W then D while W still held
    step("wd_w", 1'b0, 1'b1, K_W);
    idle("wd_hold", 4, K_W);
    step("wd_d", 1'b0, 1'b1, K_W | K_D);
    idle("wd_rep", 16, K_W | K_D);
    step("wd_rel", 1'b0, 1'b1, '0);
    idle("wd_idle", 4, '0);

    // ENTER held for 40 cycles: single pulse
    step("en_press", 1'b0, 1'b1, K_EN);
    idle("en_hold", 40, K_EN);
    step("en_rel", 1'b0, 1'b1, '0);
    idle("en_idle", 4, '0);

    // S repeating, ENTER lands on a repeat tick
    step("s_press", 1'b0, 1'b1, K_S);
    idle("s_hold", 11, K_S);
    step("s_en", 1'b0, 1'b1, K_S | K_EN);
    idle("s_rep", 10, K_S | K_EN);
    step("s_rel", 1'b0, 1'b1, '0);
    idle("s_idle", 3, '0);

    // A held, reset during DELAY, then fresh key_valid
    step("a_press", 1'b0, 1'b1, K_A);
    idle("a_hold", 3, K_A);
    step("a_rst", 1'b1, 1'b0, K_A);
    step("a_rst", 1'b1, 1'b0, K_A);
    idle("a_post", 12, K_A);
    step("a_again", 1'b0, 1'b1, K_A);
    idle("a_hold2", 10, K_A);
    step("a_same", 1'b0, 1'b1, K_A);
    idle("a_hold3", 6, K_A);
    step("a_rel", 1'b0, 1'b1, '0);
    idle("a_idle", 3, '0);

    // multiple simultaneous rises
    step("multi", 1'b0, 1'b1, K_D | K_A | K_S | K_EN);
    idle("multi_hold", 14, K_D | K_A | K_S | K_EN);
    step("multi_rel", 1'b0, 1'b1, '0);
    idle("multi_idle", 3, '0);

    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step("rnd_rst", 1'b1, 1'b0, cur);
      end else if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          cur = 5'($urandom_range(0, 31));
        else
          cur[$urandom_range(0, 4)] ^= 1'b1;
        step("rnd_kv", 1'b0, 1'b1, cur);
      end else begin
        step("rnd", 1'b0, 1'b0, 5'($urandom_range(0, 31)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
